// File: rtl/q_os_sched_pkg.sv
// Shared definitions for the frame scheduler: FSM encoding, telemetry word
// layout and the default watchdog length.
package q_os_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_LOG,
        S_WAIT_PERIOD
    } sched_state_e;

    // Telemetry word bit positions
    localparam int TELEM_TO      = 31;
    localparam int TELEM_EN      = 30;
    localparam int TELEM_BURST   = 29;
    localparam int TELEM_LAST    = 28;
    localparam int TELEM_SEQ_HI  = 27;
    localparam int TELEM_SEQ_LO  = 12;
    localparam int TELEM_DATA_HI = 11;
    localparam int TELEM_DATA_LO = 0;

    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // Assemble one telemetry word from its fields
    function automatic logic [31:0] telem_pack(
        input logic        to,
        input logic        en,
        input logic        burst,
        input logic        last,
        input logic [15:0] seq,
        input logic [11:0] data
    );
        logic [31:0] w;
        w                             = '0;
        w[TELEM_TO]                   = to;
        w[TELEM_EN]                   = en;
        w[TELEM_BURST]                = burst;
        w[TELEM_LAST]                 = last;
        w[TELEM_SEQ_HI:TELEM_SEQ_LO]  = seq;
        w[TELEM_DATA_HI:TELEM_DATA_LO] = data;
        return w;
    endfunction

endpackage

// File: rtl/q_os_interval_timer.sv
// Elapsed-cycle counter with restart and an elapsed>=limit compare.
// After a restart edge the count reads 1, so in any later cycle it holds the
// number of cycles since the restart cycle. Saturates instead of wrapping.
module q_os_interval_timer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        restart_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] cnt_q;

    // Count cycles since the last restart, holding at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              cnt_q <= '0;
        else if (restart_i)       cnt_q <= 16'd1;
        else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/q_os_frame_scheduler.sv
// Frame scheduler: paces transceiver starts at a programmable period in
// continuous or armed-burst mode, watches each transaction with a timeout,
// and writes one tagged telemetry word per frame.
module q_os_frame_scheduler
    import q_os_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int ADDR_W         = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              arm_i,
    input  logic [15:0]       period_i,
    input  logic [7:0]        burst_len_i,
    input  logic              clr_err_i,
    output logic              trx_start_o,
    input  logic              trx_done_i,
    input  logic [11:0]       trx_adc_data_i,
    output logic              telem_we_o,
    output logic [ADDR_W-1:0] telem_addr_o,
    output logic [31:0]       telem_wdata_o,
    output logic              busy_o,
    output logic              timeout_err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);

    sched_state_e      state_q, state_d;
    logic [7:0]        remaining_q, remaining_d;
    logic              burst_mode_q, burst_mode_d;
    logic [ADDR_W-1:0] telem_addr_q, telem_addr_d;
    logic [31:0]       telem_wdata_q, telem_wdata_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              trx_start_q, telem_we_q, busy_q;

    logic              timer_restart;
    logic              ivl_expired, wd_expired;
    logic [15:0]       ivl_limit;
    logic              last_frame;

    // The interval compare fires one cycle early so that the START state
    // lands exactly period cycles after the previous START.
    assign ivl_limit     = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
    assign timer_restart = (state_q == S_START);
    assign last_frame    = burst_mode_q && (remaining_q == 8'd1);

    q_os_interval_timer u_ivl_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .restart_i (timer_restart),
        .limit_i   (ivl_limit),
        .expired_o (ivl_expired)
    );

    q_os_interval_timer u_wd_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .restart_i (timer_restart),
        .limit_i   (WD_LIMIT),
        .expired_o (wd_expired)
    );

    // Next-state and datapath update; clr_err loses to a same-cycle timeout
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        burst_mode_d  = burst_mode_q;
        telem_addr_d  = telem_addr_q;
        telem_wdata_d = telem_wdata_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q & ~clr_err_i;

        unique case (state_q)
            S_IDLE: begin
                if (enable_i && ((burst_len_i == 8'd0) || arm_i)) begin
                    state_d      = S_START;
                    remaining_d  = burst_len_i;
                    burst_mode_d = (burst_len_i != 8'd0);
                end
            end
            S_START: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // A completion in the expiry cycle still counts as success
                if (trx_done_i) begin
                    state_d       = S_LOG;
                    telem_wdata_d = telem_pack(1'b0, enable_i, burst_mode_q,
                                               last_frame, frame_cnt_q,
                                               trx_adc_data_i);
                end else if (wd_expired) begin
                    state_d       = S_LOG;
                    timeout_err_d = 1'b1;
                    telem_wdata_d = telem_pack(1'b1, enable_i, burst_mode_q,
                                               last_frame, frame_cnt_q, 12'd0);
                end
            end
            S_LOG: begin
                telem_addr_d = telem_addr_q + ADDR_W'(1);
                frame_cnt_d  = frame_cnt_q + 16'd1;
                if (burst_mode_q) remaining_d = remaining_q - 8'd1;
                if (!enable_i || last_frame) state_d = S_IDLE;
                else                         state_d = S_WAIT_PERIOD;
            end
            S_WAIT_PERIOD: begin
                if (!enable_i)        state_d = S_IDLE;
                else if (ivl_expired) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered strobes derived from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            burst_mode_q  <= 1'b0;
            telem_addr_q  <= '0;
            telem_wdata_q <= '0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            trx_start_q   <= 1'b0;
            telem_we_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            burst_mode_q  <= burst_mode_d;
            telem_addr_q  <= telem_addr_d;
            telem_wdata_q <= telem_wdata_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
            trx_start_q   <= (state_d == S_START);
            telem_we_q    <= (state_d == S_LOG);
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign trx_start_o   = trx_start_q;
    assign telem_we_o    = telem_we_q;
    assign telem_addr_o  = telem_addr_q;
    assign telem_wdata_o = telem_wdata_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = timeout_err_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_q_os_frame_scheduler.sv
// Self-checking bench for q_os_frame_scheduler: a table of continuous-mode
// period/latency cases plus directed burst, watchdog, enable-drop, address
// wrap and mid-frame reset sequences. A small transceiver responder answers
// each trx_start after a programmable latency (0 = never answers).
module tb_q_os_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, arm = 1'b0, clr_err = 1'b0, trx_done = 1'b0;
    logic [15:0] period = '0;
    logic [7:0]  burst_len = '0;
    logic [11:0] adc = '0;
    logic        trx_start, telem_we, busy, timeout_err;
    logic [7:0]  telem_addr;
    logic [31:0] telem_wdata;
    logic [15:0] frame_cnt;

    int checks = 0, failures = 0;
    int cyc = 0, dcnt = 0, lat = 0, n_st = 0, n_wr = 0;
    int st_cyc[300], wr_cyc[300];
    logic [31:0] wr_data[300];
    logic [7:0]  wr_addr[300];

    typedef struct {
        logic [15:0] period;
        int          lat;
        int          ivl;
    } row_t;
    row_t rows[6];

    q_os_frame_scheduler #(.TIMEOUT_CYCLES(1024), .ADDR_W(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .arm_i          (arm),
        .period_i       (period),
        .burst_len_i    (burst_len),
        .clr_err_i      (clr_err),
        .trx_start_o    (trx_start),
        .trx_done_i     (trx_done),
        .trx_adc_data_i (adc),
        .telem_we_o     (telem_we),
        .telem_addr_o   (telem_addr),
        .telem_wdata_o  (telem_wdata),
        .busy_o         (busy),
        .timeout_err_o  (timeout_err),
        .frame_cnt_o    (frame_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge, run the responder, log events
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        arm = 1'b0;
        trx_done = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                trx_done = 1'b1;
                adc = 12'h5A0 + 12'(n_st);
            end
        end
        if (trx_start && lat > 0) dcnt = lat;
        if (trx_start && n_st < 300) begin
            st_cyc[n_st] = cyc;
            n_st++;
        end
        if (telem_we && n_wr < 300) begin
            wr_cyc[n_wr]  = cyc;
            wr_addr[n_wr] = telem_addr;
            wr_data[n_wr] = telem_wdata;
            n_wr++;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; enable = 1'b0; arm = 1'b0; clr_err = 1'b0;
        trx_done = 1'b0; dcnt = 0; lat = 0; burst_len = '0; period = '0;
        step(); step();
        rst_n = 1'b1;
        n_st = 0; n_wr = 0;
        step();
    endtask

    task automatic wait_wr(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (n_wr < n && k < budget) begin
            step();
            k++;
        end
        chk(nm, 32'(n_wr >= n), 32'd1);
    endtask

    initial begin
        int en_cyc, s0, k;

        rows[0] = '{16'd20, 10, 20};
        rows[1] = '{16'd5,  10, 13};
        rows[2] = '{16'd0,  1,  4};
        rows[3] = '{16'd1,  3,  6};
        rows[4] = '{16'd30, 27, 30};
        rows[5] = '{16'd16, 20, 23};

        // Reset state
        reset_dut();
        chk("rst_start", 32'(trx_start), 0);
        chk("rst_we",    32'(telem_we), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_err",   32'(timeout_err), 0);
        chk("rst_addr",  32'(telem_addr), 0);
        chk("rst_wdata", telem_wdata, 0);
        chk("rst_fcnt",  32'(frame_cnt), 0);

        // Continuous-mode table
        for (int r = 0; r < 6; r++) begin
            reset_dut();
            period = rows[r].period;
            lat    = rows[r].lat;
            enable = 1'b1;
            en_cyc = cyc;
            wait_wr(3, 600, $sformatf("r%0d_wr3", r));
            chk($sformatf("r%0d_lat", r),   32'(st_cyc[0] - en_cyc), 1);
            chk($sformatf("r%0d_ivl1", r),  32'(st_cyc[1] - st_cyc[0]), 32'(rows[r].ivl));
            chk($sformatf("r%0d_ivl2", r),  32'(st_cyc[2] - st_cyc[1]), 32'(rows[r].ivl));
            chk($sformatf("r%0d_wrcyc", r), 32'(wr_cyc[0] - st_cyc[0]), 32'(rows[r].lat + 1));
            chk($sformatf("r%0d_a0", r), 32'(wr_addr[0]), 0);
            chk($sformatf("r%0d_a1", r), 32'(wr_addr[1]), 1);
            chk($sformatf("r%0d_a2", r), 32'(wr_addr[2]), 2);
            chk($sformatf("r%0d_d0", r), wr_data[0], 32'h4000_05A1);
            chk($sformatf("r%0d_d1", r), wr_data[1], 32'h4000_15A2);
            chk($sformatf("r%0d_d2", r), wr_data[2], 32'h4000_25A3);
            step();
            chk($sformatf("r%0d_fcnt", r), 32'(frame_cnt), 3);
        end

        // Burst of 3 with a second arm while busy
        reset_dut();
        period = 16'd8; lat = 3; burst_len = 8'd3; enable = 1'b1;
        repeat (5) step();
        chk("burst_noarm", 32'(n_st), 0);
        arm = 1'b1;
        step();
        chk("burst_arm_start", 32'(trx_start), 1);
        chk("burst_busy_rise", 32'(busy), 1);
        wait_wr(1, 50, "burst_wr1");
        arm = 1'b1;
        step();
        repeat (60) step();
        chk("burst_nwr", 32'(n_wr), 3);
        chk("burst_nst", 32'(n_st), 3);
        chk("burst_d0", wr_data[0], 32'h6000_05A1);
        chk("burst_d1", wr_data[1], 32'h6000_15A2);
        chk("burst_d2", wr_data[2], 32'h7000_25A3);
        chk("burst_busy", 32'(busy), 0);
        chk("burst_fcnt", 32'(frame_cnt), 3);

        // Watchdog: transceiver never answers
        reset_dut();
        period = 16'd20; lat = 0; burst_len = 8'd1; enable = 1'b1;
        arm = 1'b1;
        step();
        s0 = cyc;
        chk("to_start", 32'(trx_start), 1);
        wait_wr(1, 1100, "to_wr");
        chk("to_wrcyc", 32'(wr_cyc[0] - s0), 1025);
        chk("to_d0", wr_data[0], 32'hF000_0000);
        chk("to_err", 32'(timeout_err), 1);
        step();
        trx_done = 1'b1; adc = 12'hFFF;
        step();
        repeat (5) step();
        chk("to_late_nwr", 32'(n_wr), 1);
        chk("to_late_busy", 32'(busy), 0);
        chk("to_sticky", 32'(timeout_err), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("to_clr", 32'(timeout_err), 0);

        // Timeout and clr_err in the same cycle: the set wins
        arm = 1'b1;
        step();
        repeat (1023) step();
        clr_err = 1'b1;
        step();
        step();
        chk("tos_we", 32'(telem_we), 1);
        chk("tos_err", 32'(timeout_err), 1);
        chk("tos_d1", wr_data[1], 32'hF000_1000);
        step();
        chk("tos_clr", 32'(timeout_err), 0);
        clr_err = 1'b0;

        // Completion in the watchdog expiry cycle counts as success
        lat = 1024;
        arm = 1'b1;
        step();
        s0 = cyc;
        wait_wr(3, 1100, "tie_wr");
        chk("tie_wrcyc", 32'(wr_cyc[2] - s0), 1025);
        chk("tie_d2", wr_data[2], 32'h7000_25A3);
        chk("tie_err", 32'(timeout_err), 0);

        // Enable falls during WAIT_DONE
        reset_dut();
        period = 16'd20; lat = 10; enable = 1'b1;
        step();
        repeat (5) step();
        enable = 1'b0;
        repeat (60) step();
        chk("endrop_nst", 32'(n_st), 1);
        chk("endrop_nwr", 32'(n_wr), 1);
        chk("endrop_d0", wr_data[0], 32'h0000_05A1);
        chk("endrop_wrcyc", 32'(wr_cyc[0] - st_cyc[0]), 11);
        chk("endrop_busy", 32'(busy), 0);

        // Address wrap over 257 frames, then reset mid-WAIT_DONE
        reset_dut();
        period = 16'd0; lat = 1; enable = 1'b1;
        wait_wr(257, 2000, "wrap_wr");
        chk("wrap_a255", 32'(wr_addr[255]), 255);
        chk("wrap_a256", 32'(wr_addr[256]), 0);
        chk("wrap_seq256", 32'(wr_data[256][27:12]), 256);
        k = 0;
        while (!trx_start && k < 20) begin
            step();
            k++;
        end
        chk("mid_start_seen", 32'(trx_start), 1);
        step();
        chk("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_start", 32'(trx_start), 0);
        chk("mid_we",    32'(telem_we), 0);
        chk("mid_busy",  32'(busy), 0);
        chk("mid_err",   32'(timeout_err), 0);
        chk("mid_addr",  32'(telem_addr), 0);
        chk("mid_wdata", telem_wdata, 0);
        chk("mid_fcnt",  32'(frame_cnt), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
